// File: rtl/rf_seq_pkg.sv
// Shared types and instruction field positions for the register-file sequencer.
// Imported by rf_sequencer and rf_seq_alu.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    OP_LDI = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MOV = 3'd3,
    OP_OUT = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational DW-bit ALU: wrap-around add, subtract, or pass-through of operand a.
// Any opcode other than ADD/SUB passes a, which covers MOV and OUT.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  // Result select; carries and borrows are discarded by the DW-bit width.
  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, reads the register file,
// waits out its registered read latency, then issues write-back or OUT/err strobes.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] rda1,
  output logic [AW-1:0] rda2,
  input  logic [DW-1:0] rdd1,
  input  logic [DW-1:0] rdd2,
  output logic          wr_en,
  output logic [AW-1:0] wra,
  output logic [DW-1:0] wrd,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          err,
  output logic          busy
);

  state_t        state_r, next_state_s;
  logic [2:0]    op_r, op_next_s;
  logic [AW-1:0] rd_r, rd_next_s;
  logic [AW-1:0] rda1_r, rda1_next_s;
  logic [AW-1:0] rda2_r, rda2_next_s;
  logic          wr_en_r, wr_en_next_s;
  logic [AW-1:0] wra_r, wra_next_s;
  logic [DW-1:0] wrd_r, wrd_next_s;
  logic          out_valid_r, out_valid_next_s;
  logic [DW-1:0] out_data_r, out_data_next_s;
  logic          err_r, err_next_s;

  logic [2:0]    instr_op_s;
  logic [AW-1:0] instr_rd_s;
  logic [AW-1:0] instr_ra_s;
  logic [AW-1:0] instr_rb_s;
  logic [DW-1:0] instr_imm_s;
  logic [DW-1:0] alu_y_s;

  assign instr_op_s  = instr[OP_MSB:OP_LSB];
  assign instr_rd_s  = AW'(instr[RD_MSB:RD_LSB]);
  assign instr_ra_s  = AW'(instr[RA_MSB:RA_LSB]);
  assign instr_rb_s  = AW'(instr[RB_MSB:RB_LSB]);
  assign instr_imm_s = DW'(instr[IMM_MSB:IMM_LSB]);

  rf_seq_alu #(.DW(DW)) u_alu (
    .op (op_r),
    .a  (rdd1),
    .b  (rdd2),
    .y  (alu_y_s)
  );

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    next_state_s     = state_r;
    op_next_s        = op_r;
    rd_next_s        = rd_r;
    rda1_next_s      = rda1_r;
    rda2_next_s      = rda2_r;
    wr_en_next_s     = 1'b0;
    wra_next_s       = wra_r;
    wrd_next_s       = wrd_r;
    out_valid_next_s = 1'b0;
    out_data_next_s  = out_data_r;
    err_next_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (instr_valid) begin
          case (instr_op_s)
            OP_LDI: begin
              wr_en_next_s = 1'b1;
              wra_next_s   = instr_rd_s;
              wrd_next_s   = instr_imm_s;
              next_state_s = S_EXEC;
            end
            OP_ADD, OP_SUB, OP_MOV, OP_OUT: begin
              op_next_s    = instr_op_s;
              rd_next_s    = instr_rd_s;
              rda1_next_s  = instr_ra_s;
              rda2_next_s  = instr_rb_s;
              next_state_s = S_READ;
            end
            default: begin
              err_next_s   = 1'b1;
              next_state_s = S_EXEC;
            end
          endcase
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_READ: next_state_s = S_WAIT;
      S_WAIT: begin
        next_state_s = S_EXEC;
        // Read data is only trustworthy here, one cycle after the RF sampled rda1/rda2.
        case (op_r)
          OP_ADD, OP_SUB, OP_MOV: begin
            wr_en_next_s = 1'b1;
            wra_next_s   = rd_r;
            wrd_next_s   = alu_y_s;
          end
          OP_OUT: begin
            out_valid_next_s = 1'b1;
            out_data_next_s  = alu_y_s;
          end
          default: begin
            wr_en_next_s = 1'b0;
          end
        endcase
      end
      S_EXEC:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      op_r        <= 3'd0;
      rd_r        <= '0;
      rda1_r      <= '0;
      rda2_r      <= '0;
      wr_en_r     <= 1'b0;
      wra_r       <= '0;
      wrd_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      op_r        <= op_next_s;
      rd_r        <= rd_next_s;
      rda1_r      <= rda1_next_s;
      rda2_r      <= rda2_next_s;
      wr_en_r     <= wr_en_next_s;
      wra_r       <= wra_next_s;
      wrd_r       <= wrd_next_s;
      out_valid_r <= out_valid_next_s;
      out_data_r  <= out_data_next_s;
      err_r       <= err_next_s;
    end
  end

  assign instr_ready = (state_r == S_IDLE);
  assign busy        = (state_r != S_IDLE);
  assign rda1        = rda1_r;
  assign rda2        = rda2_r;
  assign wr_en       = wr_en_r;
  assign wra         = wra_r;
  assign wrd         = wrd_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign err         = err_r;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench for rf_sequencer with a bench-side register file, a latency-level
// reference model compared every cycle, and hand-computed literal checks.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] instr = 12'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  rda1, rda2, wra;
  logic [3:0]  rdd1, rdd2, wrd, out_data;
  logic        wr_en, out_valid, err, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  rf_sequencer #(.DW(4), .AW(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rda1(rda1), .rda2(rda2), .rdd1(rdd1), .rdd2(rdd2),
    .wr_en(wr_en), .wra(wra), .wrd(wrd), .out_valid(out_valid),
    .out_data(out_data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle registered read.
  logic [3:0] rf [8];
  always @(posedge clk) begin
    if (wr_en) rf[wra] <= wrd;
    rdd1 <= rf[rda1];
    rdd2 <= rf[rda2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference model: instruction semantics plus cycle count to completion.
  int         m_left;
  logic [2:0] m_op, m_rd, m_ra, m_rb;
  logic [3:0] m_imm, m_out;
  logic [3:0] m_reg [8];

  function automatic logic m_writes(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  function automatic logic [3:0] m_value(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] imm);
    int r;
    case (op)
      3'd0: r = int'(imm);
      3'd1: r = (int'(a) + int'(b)) % 16;
      3'd2: r = (int'(a) - int'(b) + 16) % 16;
      default: r = int'(a);
    endcase
    return r[3:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= 4'd0;
    end else if (m_left == 0) begin
      if (instr_valid) begin
        m_op   <= instr[11:9];
        m_rd   <= instr[8:6];
        m_ra   <= instr[5:3];
        m_rb   <= instr[2:0];
        m_imm  <= instr[3:0];
        m_left <= (instr[11:9] >= 3'd1 && instr[11:9] <= 3'd4) ? 3 : 1;
      end
    end else begin
      if (m_left == 1) begin
        if (m_writes(m_op)) m_reg[m_rd] <= m_value(m_op, m_reg[m_ra], m_reg[m_rb], m_imm);
        if (m_op == 3'd4) m_out <= m_reg[m_ra];
      end
      m_left <= m_left - 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, m_left == 0});
      chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
      chk("wr_en", {31'd0, wr_en}, {31'd0, m_left == 1 && m_writes(m_op)});
      if (m_left == 1 && m_writes(m_op)) begin
        chk("wra", {29'd0, wra}, {29'd0, m_rd});
        chk("wrd", {28'd0, wrd}, {28'd0, m_value(m_op, m_reg[m_ra], m_reg[m_rb], m_imm)});
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_left == 1 && m_op == 3'd4});
      chk("err", {31'd0, err}, {31'd0, m_left == 1 && m_op > 3'd4});
      chk("out_data", {28'd0, out_data},
          {28'd0, (m_left == 1 && m_op == 3'd4) ? m_reg[m_ra] : m_out});
    end
  end

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [11:0] ldi(input logic [2:0] rd, input logic [3:0] imm);
    return {3'd0, rd, 2'd0, imm};
  endfunction

  task automatic issue(input logic [11:0] w);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wra", {29'd0, wra}, 32'd0);
    chk("rst_wrd", {28'd0, wrd}, 32'd0);
    chk("rst_rda1", {29'd0, rda1}, 32'd0);
    chk("rst_rda2", {29'd0, rda2}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    skip(3);
    chk_reset_vals();
    rst = 1'b0;

    // LDI R3,#9: one-cycle write then ready again
    issue(ldi(3'd3, 4'd9));
    skip(1);
    chk("ldi_wr_en", {31'd0, wr_en}, 32'd1);
    chk("ldi_wra", {29'd0, wra}, 32'd3);
    chk("ldi_wrd", {28'd0, wrd}, 32'd9);
    skip(1);
    chk("ldi_wr_en_clear", {31'd0, wr_en}, 32'd0);
    chk("ldi_ready_back", {31'd0, instr_ready}, 32'd1);

    // 15 + 1 wraps to 0; 1 - 15 wraps to 2
    issue(ldi(3'd1, 4'd15));
    issue(ldi(3'd2, 4'd1));
    issue(mk(3'd1, 3'd4, 3'd1, 3'd2));
    skip(2);
    chk("add_not_early", {31'd0, wr_en}, 32'd0);
    skip(1);
    chk("add_wra", {29'd0, wra}, 32'd4);
    chk("add_wrd", {28'd0, wrd}, 32'd0);
    issue(mk(3'd2, 3'd5, 3'd2, 3'd1));
    skip(3);
    chk("sub_wrd", {28'd0, wrd}, 32'd2);

    // Dependent MOV right after the ADD that produces its source
    issue(mk(3'd1, 3'd4, 3'd1, 3'd3));
    skip(3);
    chk("add2_wrd", {28'd0, wrd}, 32'd8);
    issue(mk(3'd3, 3'd6, 3'd4, 3'd0));
    skip(3);
    chk("mov_wra", {29'd0, wra}, 32'd6);
    chk("mov_wrd", {28'd0, wrd}, 32'd8);

    // OUT R3
    issue(mk(3'd4, 3'd0, 3'd3, 3'd0));
    skip(2);
    chk("out_not_early", {31'd0, out_valid}, 32'd0);
    skip(1);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", {28'd0, out_data}, 32'd9);
    chk("out_no_write", {31'd0, wr_en}, 32'd0);
    skip(1);
    chk("out_valid_clear", {31'd0, out_valid}, 32'd0);
    chk("out_data_hold", {28'd0, out_data}, 32'd9);

    // Illegal opcode 110
    issue(mk(3'd6, 3'd2, 3'd1, 3'd1));
    skip(1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_no_write", {31'd0, wr_en}, 32'd0);
    skip(1);
    chk("ill_err_clear", {31'd0, err}, 32'd0);
    chk("ill_ready", {31'd0, instr_ready}, 32'd1);

    // rd == ra: 15 + 15 = 14; then 0 - 1 = 15
    issue(mk(3'd1, 3'd1, 3'd1, 3'd1));
    skip(3);
    chk("self_add_wrd", {28'd0, wrd}, 32'd14);
    issue(ldi(3'd0, 4'd0));
    issue(mk(3'd2, 3'd5, 3'd0, 3'd2));
    skip(3);
    chk("sub_wrap_wrd", {28'd0, wrd}, 32'd15);

    // Reset during WAIT of an ADD drops the write
    issue(mk(3'd1, 3'd7, 3'd1, 3'd2));
    skip(2);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    skip(1);
    chk("rst_hold_wr_en", {31'd0, wr_en}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      skip(1);
      chk("rst_dropped_write", {31'd0, wr_en}, 32'd0);
    end
    issue(ldi(3'd7, 4'd5));
    skip(1);
    chk("post_rst_wra", {29'd0, wra}, 32'd7);
    chk("post_rst_wrd", {28'd0, wrd}, 32'd5);
    issue(mk(3'd4, 3'd0, 3'd7, 3'd0));
    skip(3);
    chk("post_rst_out", {28'd0, out_data}, 32'd5);
    skip(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
